// File: rtl/snake_pixel_renderer.sv
// Snake playfield pixel source running in lockstep with the VGA driver raster.
// Optional macro GRID_LINES_EN draws dim grid lines in empty cells.
module snake_pixel_renderer #(
  parameter int          GRID_W     = 20,
  parameter int          GRID_H     = 15,
  parameter int          CELL_SHIFT = 5,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [11:0] BODY_RGB   = 12'h0C0,
  parameter logic [11:0] HEAD_RGB   = 12'hFF0,
  parameter logic [11:0] FOOD_RGB   = 12'hF00,
  parameter int          H_TOTAL    = 800,
  parameter int          V_TOTAL    = 525
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [1:0] upd_op,
  input  logic [4:0] upd_x,
  input  logic [3:0] upd_y,
  output logic       upd_drop,
  output logic       vblank,
  output logic [3:0] SnakeRed,
  output logic [3:0] SnakeGreen,
  output logic [3:0] SnakeBlue,
  output logic       ACTIVE
);

  localparam int H_VIS = GRID_W << CELL_SHIFT;
  localparam int V_VIS = GRID_H << CELL_SHIFT;
  localparam int CELLS = GRID_W * GRID_H;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  function automatic logic [8:0] cell_index(input logic [4:0] cx, input logic [3:0] cy);
    return ({5'd0, cy} * 9'(GRID_W)) + {4'd0, cx};
  endfunction

  logic [9:0]       px_r, py_r;
  logic             synced_r;
  logic [CELLS-1:0] bitmap_r;
  logic [4:0]       head_x_r, food_x_r;
  logic [3:0]       head_y_r, food_y_r;
  logic [10:0]      fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic [9:0]       nx_s, ny_s;
  logic             nsync_s;
  logic [4:0]       cx_s;
  logic [3:0]       cy_s;
  logic [8:0]       cell_idx_s;
  logic             vis_s;
  logic [11:0]      rgb_s;

  logic             push_s, pop_s, in_range_s;
  logic [1:0]       pop_op_s;
  logic [4:0]       pop_x_s;
  logic [3:0]       pop_y_s;
  logic [8:0]       pop_idx_s;
  logic [CNT_W-1:0] count_next_s;

  // Next raster position; frame_start always lands on (2,0), which also resyncs.
  always_comb begin
    nx_s    = px_r;
    ny_s    = py_r;
    nsync_s = synced_r;
    if (frame_start) begin
      nx_s    = 10'd2;
      ny_s    = 10'd0;
      nsync_s = 1'b1;
    end else if (px_r == 10'(H_TOTAL - 1)) begin
      nx_s = 10'd0;
      if (py_r == 10'(V_TOTAL - 1)) begin
        ny_s = 10'd0;
      end else begin
        ny_s = py_r + 10'd1;
      end
    end else begin
      nx_s = px_r + 10'd1;
    end
  end

  // Colour of the pixel the raster moves to, so the registers hold the current pixel.
  always_comb begin
    cx_s       = 5'(nx_s >> CELL_SHIFT);
    cy_s       = 4'(ny_s >> CELL_SHIFT);
    cell_idx_s = cell_index(cx_s, cy_s);
    vis_s      = nsync_s && (nx_s < 10'(H_VIS)) && (ny_s < 10'(V_VIS));
    rgb_s      = 12'h000;
    if (vis_s) begin
      if ((cx_s == head_x_r) && (cy_s == head_y_r)) begin
        rgb_s = HEAD_RGB;
      end else if ((cx_s == food_x_r) && (cy_s == food_y_r)) begin
        rgb_s = FOOD_RGB;
      end else if (bitmap_r[cell_idx_s]) begin
        rgb_s = BODY_RGB;
      end else begin
`ifdef GRID_LINES_EN
        if ((nx_s[CELL_SHIFT-1:0] == {CELL_SHIFT{1'b0}}) ||
            (ny_s[CELL_SHIFT-1:0] == {CELL_SHIFT{1'b0}})) begin
          rgb_s = 12'h222;
        end else begin
          rgb_s = 12'h000;
        end
`else
        rgb_s = 12'h000;
`endif
      end
    end else begin
      rgb_s = 12'h000;
    end
  end

  // Queue bookkeeping; commits are only allowed during vertical blanking.
  always_comb begin
    push_s       = upd_valid && upd_ready;
    pop_s        = vblank && (count_r != {CNT_W{1'b0}});
    {pop_op_s, pop_x_s, pop_y_s} = fifo_mem_r[rd_ptr_r];
    in_range_s   = (pop_x_s < 5'(GRID_W)) && (pop_y_s < 4'(GRID_H));
    pop_idx_s    = cell_index(pop_x_s, pop_y_s);
    count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Raster counters and registered pixel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_r       <= 10'd0;
      py_r       <= 10'd0;
      synced_r   <= 1'b0;
      vblank     <= 1'b0;
      ACTIVE     <= 1'b0;
      SnakeRed   <= 4'h0;
      SnakeGreen <= 4'h0;
      SnakeBlue  <= 4'h0;
    end else begin
      px_r       <= nx_s;
      py_r       <= ny_s;
      synced_r   <= nsync_s;
      vblank     <= (ny_s >= 10'(V_VIS));
      ACTIVE     <= vis_s;
      SnakeRed   <= rgb_s[11:8];
      SnakeGreen <= rgb_s[7:4];
      SnakeBlue  <= rgb_s[3:0];
    end
  end

  // Update queue storage, pointers and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      upd_ready <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 11'd0;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {upd_op, upd_x, upd_y};
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r   <= count_next_s;
      upd_ready <= (count_next_s != CNT_W'(FIFO_DEPTH));
    end
  end

  // Playfield state: committed updates and the out-of-range drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_r <= {CELLS{1'b0}};
      head_x_r <= 5'd0;
      head_y_r <= 4'd0;
      food_x_r <= 5'd0;
      food_y_r <= 4'd0;
      upd_drop <= 1'b0;
    end else begin
      upd_drop <= pop_s && !in_range_s;
      if (pop_s && in_range_s) begin
        case (pop_op_s)
          2'b00:   bitmap_r[pop_idx_s] <= 1'b0;
          2'b01:   bitmap_r[pop_idx_s] <= 1'b1;
          2'b10: begin
            head_x_r <= pop_x_s;
            head_y_r <= pop_y_s;
          end
          2'b11: begin
            food_x_r <= pop_x_s;
            food_y_r <= pop_y_s;
          end
          default: bitmap_r <= bitmap_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Directed bench for snake_pixel_renderer on a shrunken 6x6 grid of 16 px cells
// (96x96 visible, 104x100 total) so several frames fit in a short run.
module tb_snake_pixel_renderer;

  localparam int GW = 6, GH = 6, CS = 4, HT = 104, VT = 100;
`ifdef GRID_LINES_EN
  localparam logic [11:0] LINE_RGB = 12'h222;
`else
  localparam logic [11:0] LINE_RGB = 12'h000;
`endif
  localparam logic [12:0] BLACK = 13'h1000;
  localparam logic [12:0] LINE  = {1'b1, LINE_RGB};
  localparam logic [12:0] HEAD  = 13'h1FF0;
  localparam logic [12:0] FOOD  = 13'h1F00;
  localparam logic [12:0] BODY  = 13'h10C0;
  localparam logic [12:0] OFF   = 13'h0000;

  logic       clk, rst_n, frame_start, upd_valid, upd_ready, upd_drop, vblank, active;
  logic [1:0] upd_op;
  logic [4:0] upd_x;
  logic [3:0] upd_y;
  logic [3:0] red, green, blue;
  int         total, bad;
  int         mx, my;

  snake_pixel_renderer #(
    .GRID_W(GW), .GRID_H(GH), .CELL_SHIFT(CS), .FIFO_DEPTH(4),
    .BODY_RGB(12'h0C0), .HEAD_RGB(12'hFF0), .FOOD_RGB(12'hF00),
    .H_TOTAL(HT), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
    .upd_x(upd_x), .upd_y(upd_y), .upd_drop(upd_drop), .vblank(vblank),
    .SnakeRed(red), .SnakeGreen(green), .SnakeBlue(blue), .ACTIVE(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference raster position, used only to know when to sample.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx <= 0;
      my <= 0;
    end else if (frame_start) begin
      mx <= 2;
      my <= 0;
    end else if (mx == HT - 1) begin
      mx <= 0;
      my <= (my == VT - 1) ? 0 : my + 1;
    end else begin
      mx <= mx + 1;
    end
  end

  task automatic wait_pix(input int x, input int y);
    bit found = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (mx == x && my == y) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL wait_pix: raster never reached (%0d,%0d)", x, y);
    end
  endtask

  task automatic wait_vblank();
    bit found = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (vblank === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL wait_vblank: vblank never rose");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_start = 1'b0; upd_valid = 1'b0;
    upd_op = 2'b00; upd_x = 5'd0; upd_y = 4'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({active, red, green, blue, upd_drop, vblank, upd_ready} !== 16'h0001) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0001",
               {active, red, green, blue, upd_drop, vblank, upd_ready});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      total++;
      if ({active, red, green, blue, upd_ready} !== 14'h0001) begin
        bad++;
        $display("FAIL unsynced_idle: cycle %0d got %h want 0001", i,
                 {active, red, green, blue, upd_ready});
      end
    end
  endtask

  task automatic test_sync();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    total++;
    if ({active, red, green, blue} !== HEAD || vblank !== 1'b0) begin
      bad++;
      $display("FAIL sync_first_pixel: got %h vb=%b want %h vb=0",
               {active, red, green, blue}, vblank, HEAD);
    end
    wait_pix(95, 0);
    total++;
    if ({active, red, green, blue} !== LINE) begin
      bad++;
      $display("FAIL last_visible_px: got %h want %h", {active, red, green, blue}, LINE);
    end
    wait_pix(96, 0);
    total++;
    if ({active, red, green, blue} !== OFF) begin
      bad++;
      $display("FAIL hblank_px: got %h want %h", {active, red, green, blue}, OFF);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ent [5];
    int          drops;
    ent[0] = {2'b01, 5'd3, 4'd2};
    ent[1] = {2'b11, 5'd25, 4'd3};
    ent[2] = {2'b10, 5'd1, 4'd1};
    ent[3] = {2'b11, 5'd5, 4'd0};
    ent[4] = {2'b01, 5'd4, 4'd2};
    wait_pix(10, 2);
    for (int k = 0; k < 4; k++) begin
      {upd_op, upd_x, upd_y} = ent[k];
      upd_valid = 1'b1;
      total++;
      if (upd_ready !== 1'b1) begin
        bad++;
        $display("FAIL push_ready: entry %0d got %b want 1", k, upd_ready);
      end
      @(negedge clk);
    end
    {upd_op, upd_x, upd_y} = ent[4];
    total++;
    if (upd_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready: got %b want 0", upd_ready);
    end
    wait_pix(49, 33);
    total++;
    if ({active, red, green, blue} !== BLACK) begin
      bad++;
      $display("FAIL no_early_commit: got %h want %h", {active, red, green, blue}, BLACK);
    end
    wait_vblank();
    total++;
    if (upd_ready !== 1'b0 || active !== 1'b0) begin
      bad++;
      $display("FAIL vblank_entry: ready=%b active=%b want 0 0", upd_ready, active);
    end
    @(negedge clk);
    total++;
    if (upd_ready !== 1'b1) begin
      bad++;
      $display("FAIL drain_ready: got %b want 1", upd_ready);
    end
    @(negedge clk);
    upd_valid = 1'b0;
    total++;
    if (upd_drop !== 1'b1) begin
      bad++;
      $display("FAIL drop_pulse: got %b want 1", upd_drop);
    end
    @(negedge clk);
    total++;
    if (upd_drop !== 1'b0) begin
      bad++;
      $display("FAIL drop_width: got %b want 0", upd_drop);
    end
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (upd_drop === 1'b1) drops++;
    end
    total++;
    if (drops != 0 || upd_ready !== 1'b1) begin
      bad++;
      $display("FAIL drain_end: drops=%0d ready=%b want 0 1", drops, upd_ready);
    end
  endtask

  task automatic test_commit_frame();
    int          xs [6];
    int          ys [6];
    logic [12:0] ex [6];
    xs = '{80, 17, 48, 64, 47, 63};
    ys = '{ 0, 17, 32, 32, 33, 47};
    ex = '{FOOD, HEAD, BODY, BODY, BLACK, BODY};
    wait_pix(1, 0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    total++;
    if ({active, red, green, blue} !== LINE || vblank !== 1'b0) begin
      bad++;
      $display("FAIL resync_on_time: got %h vb=%b want %h vb=0",
               {active, red, green, blue}, vblank, LINE);
    end
    for (int i = 0; i < 6; i++) begin
      wait_pix(xs[i], ys[i]);
      total++;
      if ({active, red, green, blue} !== ex[i]) begin
        bad++;
        $display("FAIL frame2_px(%0d,%0d): got %h want %h", xs[i], ys[i],
                 {active, red, green, blue}, ex[i]);
      end
    end
    wait_pix(96, 47);
    total++;
    if ({active, red, green, blue} !== OFF) begin
      bad++;
      $display("FAIL frame2_hblank: got %h want %h", {active, red, green, blue}, OFF);
    end
    wait_pix(10, 60);
    for (int k = 0; k < 2; k++) begin
      upd_op = (k == 0) ? 2'b10 : 2'b11;
      upd_x = 5'd0; upd_y = 4'd0; upd_valid = 1'b1;
      total++;
      if (upd_ready !== 1'b1) begin
        bad++;
        $display("FAIL push2_ready: entry %0d got %b want 1", k, upd_ready);
      end
      @(negedge clk);
    end
    upd_valid = 1'b0;
  endtask

  task automatic test_head_food_overlap();
    int          xs [6];
    int          ys [6];
    logic [12:0] ex [6];
    xs = '{0, 17, 80, 81, 80, 81};
    ys = '{0, 17,  5,  5, 90, 90};
    ex = '{HEAD, BLACK, LINE, BLACK, LINE, BLACK};
    for (int i = 0; i < 6; i++) begin
      wait_pix(xs[i], ys[i]);
      total++;
      if ({active, red, green, blue} !== ex[i]) begin
        bad++;
        $display("FAIL frame3_px(%0d,%0d): got %h want %h", xs[i], ys[i],
                 {active, red, green, blue}, ex[i]);
      end
    end
    wait_pix(0, 96);
    total++;
    if (vblank !== 1'b1 || {active, red, green, blue} !== OFF) begin
      bad++;
      $display("FAIL vblank_row: vb=%b px=%h want 1 %h", vblank, {active, red, green, blue}, OFF);
    end
  endtask

  task automatic test_resync_in_vblank();
    wait_pix(50, 97);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    total++;
    if (vblank !== 1'b0 || {active, red, green, blue} !== HEAD) begin
      bad++;
      $display("FAIL early_resync: vb=%b px=%h want 0 %h", vblank, {active, red, green, blue}, HEAD);
    end
    @(negedge clk);
    total++;
    if ({active, red, green, blue} !== HEAD) begin
      bad++;
      $display("FAIL early_resync_next: got %h want %h", {active, red, green, blue}, HEAD);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sync();
    test_back_to_back();
    test_commit_frame();
    test_head_food_overlap();
    test_resync_in_vblank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
